// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// ALU-op codes and datapath select values, plus the control-word layout that
// the output decoder hands back to the FSM top level.
package mips_ctrl_pkg;

  localparam int OPCODE_W = 6;
  localparam int ALU_OP_W = 2;
  localparam int STATE_W  = 4;

  // Instruction opcodes understood by the controller
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  // ALU-op codes, also consumed by alu_control
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_OP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALU_SRC_B_RT      = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SHL = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Encodings are visible on the debug state port, so they are fixed values
  typedef enum logic [STATE_W-1:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_ALU_WB    = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11
  } state_t;

  // Per-state datapath control word, before ready/enable/reset gating
  typedef struct packed {
    logic                pc_write;
    logic                pc_write_cond;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mdr_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          pc_source;
  } ctrl_word_t;

  // States that hold until the unified memory signals completion
  function automatic logic waits_on_mem(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
  endfunction

  // Load/store share the address-calculation step
  function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Bundle between the control FSM and the multicycle datapath/memory.
// master = controller side (drives the o_* controls), slave = datapath side.
// Widths default to the shared package values.
interface multicycle_control_fsm_if #(
  parameter int NB_OPCODE = mips_ctrl_pkg::OPCODE_W,
  parameter int NB_ALU_OP = mips_ctrl_pkg::ALU_OP_W,
  parameter int NB_STATE  = mips_ctrl_pkg::STATE_W
);
  logic [NB_OPCODE-1:0] i_opcode;
  logic                 i_mem_ready;
  logic                 i_enable;
  logic                 o_pc_write;
  logic                 o_pc_write_cond;
  logic                 o_iord;
  logic                 o_mem_read;
  logic                 o_mem_write;
  logic                 o_ir_write;
  logic                 o_mdr_write;
  logic                 o_mem_to_reg;
  logic                 o_reg_dst;
  logic                 o_reg_write;
  logic                 o_alu_src_a;
  logic [1:0]           o_alu_src_b;
  logic [NB_ALU_OP-1:0] o_alu_op;
  logic [1:0]           o_pc_source;
  logic                 o_instr_done;
  logic                 o_illegal_op;
  logic [NB_STATE-1:0]  o_state;

  modport master (
    input  i_opcode, i_mem_ready, i_enable,
    output o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write,
           o_ir_write, o_mdr_write, o_mem_to_reg, o_reg_dst, o_reg_write,
           o_alu_src_a, o_alu_src_b, o_alu_op, o_pc_source,
           o_instr_done, o_illegal_op, o_state
  );

  modport slave (
    output i_opcode, i_mem_ready, i_enable,
    input  o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write,
           o_ir_write, o_mdr_write, o_mem_to_reg, o_reg_dst, o_reg_write,
           o_alu_src_a, o_alu_src_b, o_alu_op, o_pc_source,
           o_instr_done, o_illegal_op, o_state
  );
endinterface

// File: rtl/multicycle_control_fsm_decode.sv
// Pure state -> control-word decode for the multicycle controller.
// Combinational, zero latency; strobes here are ungated (ready/enable applied by the top).
// No backpressure of its own.
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t ctrl
);

  // Each state only sets the fields it uses; everything else stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_source = PC_SRC_ALU;
      end
      ST_DECODE: begin
        // Speculative branch target: PC + (imm << 2)
        ctrl.alu_src_b = ALU_SRC_B_IMM_SHL;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      ST_MEM_READ: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.mdr_write = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      ST_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_RT;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      ST_ALU_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      ST_ADDI_WB: begin
        ctrl.reg_dst   = 1'b0;
        ctrl.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALU_SRC_B_RT;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath (fetch/decode/exec/mem/wb).
// Outputs are combinational from state (0 cycles); state advances once per enabled clock.
// Stalls in FETCH/MEM_READ/MEM_WRITE until i_mem_ready; i_enable=0 freezes state and kills strobes.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int NB_OPCODE = OPCODE_W,
  parameter int NB_ALU_OP = ALU_OP_W,
  parameter int NB_STATE  = STATE_W
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  multicycle_control_fsm_if.master bus
);

  state_t               state_q;
  state_t               state_nxt_raw;
  state_t               state_d;
  logic                 illegal_raw;
  logic                 done_raw;
  ctrl_word_t           ctrl_raw;
  ctrl_word_t           ctrl;
  logic                 instr_done;
  logic                 illegal_op;
  logic                 mem_gate;
  logic [NB_OPCODE-1:0] opcode;
  logic [NB_ALU_OP-1:0] alu_op;
  logic [NB_STATE-1:0]  state_dbg;

  assign opcode = bus.i_opcode;

  ctrl_output_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl_raw)
  );

  // State register; reset aborts any instruction straight back to FETCH
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing, instruction-complete and illegal-opcode detection
  always_comb begin
    state_nxt_raw = state_q;
    illegal_raw   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (bus.i_mem_ready) state_nxt_raw = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_mem_op(opcode)) begin
          state_nxt_raw = ST_MEM_ADDR;
        end else begin
          case (opcode)
            OP_RTYPE: state_nxt_raw = ST_EXECUTE;
            OP_BEQ:   state_nxt_raw = ST_BRANCH;
            OP_J:     state_nxt_raw = ST_JUMP;
            OP_ADDI:  state_nxt_raw = ST_ADDI_EXEC;
            default: begin
              state_nxt_raw = ST_FETCH;
              illegal_raw   = 1'b1;
            end
          endcase
        end
      end
      // IR is stable for the whole instruction, so the opcode still selects load vs store here
      ST_MEM_ADDR:  state_nxt_raw = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ: begin
        if (bus.i_mem_ready) state_nxt_raw = ST_MEM_WB;
      end
      ST_MEM_WRITE: begin
        if (bus.i_mem_ready) state_nxt_raw = ST_FETCH;
      end
      ST_EXECUTE:   state_nxt_raw = ST_ALU_WB;
      ST_ADDI_EXEC: state_nxt_raw = ST_ADDI_WB;
      ST_MEM_WB, ST_ALU_WB, ST_ADDI_WB, ST_BRANCH, ST_JUMP: state_nxt_raw = ST_FETCH;
      default:      state_nxt_raw = ST_FETCH;
    endcase

    // Returning to FETCH from FETCH (stall) or DECODE (illegal) is not a completed instruction
    done_raw = (state_nxt_raw == ST_FETCH) &&
               (state_q != ST_FETCH) && (state_q != ST_DECODE);

    state_d = bus.i_enable ? state_nxt_raw : state_q;
  end

  // Apply memory-ready, enable and reset gating to the decoded control word
  always_comb begin
    ctrl       = ctrl_raw;
    instr_done = done_raw;
    illegal_op = illegal_raw;

    // Loads of IR/PC in FETCH and MDR in MEM_READ only happen on the completing cycle
    mem_gate       = waits_on_mem(state_q) ? bus.i_mem_ready : 1'b1;
    ctrl.pc_write  = ctrl_raw.pc_write  & mem_gate;
    ctrl.ir_write  = ctrl_raw.ir_write  & mem_gate;
    ctrl.mdr_write = ctrl_raw.mdr_write & mem_gate;

    // Frozen: selects stay state-decoded, every side-effecting strobe is dropped
    if (!bus.i_enable) begin
      ctrl.pc_write      = 1'b0;
      ctrl.pc_write_cond = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.mdr_write     = 1'b0;
      ctrl.reg_write     = 1'b0;
      ctrl.mem_read      = 1'b0;
      ctrl.mem_write     = 1'b0;
      instr_done         = 1'b0;
      illegal_op         = 1'b0;
    end

    if (i_reset) begin
      ctrl       = '0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign alu_op    = ctrl.alu_op;
  assign state_dbg = state_q;

  assign bus.o_pc_write      = ctrl.pc_write;
  assign bus.o_pc_write_cond = ctrl.pc_write_cond;
  assign bus.o_iord          = ctrl.iord;
  assign bus.o_mem_read      = ctrl.mem_read;
  assign bus.o_mem_write     = ctrl.mem_write;
  assign bus.o_ir_write      = ctrl.ir_write;
  assign bus.o_mdr_write     = ctrl.mdr_write;
  assign bus.o_mem_to_reg    = ctrl.mem_to_reg;
  assign bus.o_reg_dst       = ctrl.reg_dst;
  assign bus.o_reg_write     = ctrl.reg_write;
  assign bus.o_alu_src_a     = ctrl.alu_src_a;
  assign bus.o_alu_src_b     = ctrl.alu_src_b;
  assign bus.o_alu_op        = alu_op;
  assign bus.o_pc_source     = ctrl.pc_source;
  assign bus.o_instr_done    = instr_done;
  assign bus.o_illegal_op    = illegal_op;
  assign bus.o_state         = state_dbg;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control state machine for the multicycle MIPS datapath. Decodes the 6-bit opcode and sequences instruction execution through fetch, decode, execute, memory and writeback steps. Drives the 2-bit ALU-op code consumed by alu_control, plus all mux selects and write strobes. Stalls on a ready handshake with the unified instruction/data memory.

Parameters:
NB_OPCODE, 6, opcode field width
NB_ALU_OP, 2, ALU-op code width (00 add, 01 subtract/branch, 10 funct-decoded)
NB_STATE, 4, state register width

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_opcode  in  NB_OPCODE  opcode from instruction register
i_mem_ready  in  1  memory completes the current read/write this cycle
i_enable  in  1  global step enable; 0 = freeze
o_pc_write  out  1  unconditional PC load
o_pc_write_cond  out  1  PC load if ALU zero
o_iord  out  1  memory address select: 0 = PC, 1 = ALUOut
o_mem_read  out  1  memory read request
o_mem_write  out  1  memory write request
o_ir_write  out  1  instruction register load
o_mdr_write  out  1  memory data register load
o_mem_to_reg  out  1  writeback select: 1 = MDR
o_reg_dst  out  1  destination register select: 1 = rd, 0 = rt
o_reg_write  out  1  register file write
o_alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
o_alu_src_b  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate
o_alu_op  out  NB_ALU_OP  ALU-op code to alu_control
o_pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
o_instr_done  out  1  one-cycle pulse on the last cycle of each instruction
o_illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
o_state  out  NB_STATE  current state (debug)

Behaviour:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- State register is async-reset to FETCH. While i_reset=1, every output is 0 except o_state=0.
- Outputs are combinational from state. Unlisted outputs are 0 in each state.
- FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=i_mem_ready. Advances to DECODE only when i_mem_ready=1; otherwise holds.
- DECODE: alu_src_b=11, alu_op=00. Next state by opcode:
  - lw/sw -> MEM_ADDR
  - R-type -> EXECUTE
  - beq -> BRANCH
  - j -> JUMP
  - addi -> ADDI_EXEC
  - any other -> FETCH, with o_illegal_op=1 in this cycle
- MEM_ADDR and ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. MEM_ADDR goes to MEM_READ (lw) or MEM_WRITE (sw); ADDI_EXEC goes to ADDI_WB.
- MEM_READ: mem_read=1, iord=1, mdr_write=i_mem_ready. Goes to MEM_WB when ready; otherwise holds.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEM_WRITE: mem_write=1, iord=1. Goes to FETCH when ready; otherwise holds.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Then ALU_WB.
- ALU_WB: reg_dst=1, reg_write=1. Then FETCH.
- ADDI_WB: reg_dst=0, reg_write=1. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Then FETCH.
- JUMP: pc_write=1, pc_source=10. Then FETCH.
- o_instr_done=1 in the cycle whose next state is FETCH. This excludes the illegal-opcode path and the not-ready cycles of MEM_WRITE.
- Zero-wait latency (cycles):
  - R-type, sw, addi: 4
  - lw: 5
  - beq, j: 3
  - illegal opcode: 2
- i_enable=0:
  - State holds.
  - All strobes forced 0: pc_write, pc_write_cond, ir_write, mdr_write, reg_write, mem_read, mem_write, instr_done, illegal_op.
  - Selects and alu_op keep their state-decoded values.
- i_mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- Reset asserted mid-instruction aborts immediately to FETCH; no partial writeback completes.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants
  - state encodings
  - ALU-op codes (ALU_OP_ADD=00, ALU_OP_SUB=01, ALU_OP_FUNCT=10), also used by alu_control
  - alu_src_b and pc_source select encodings
- One sub-module, ctrl_output_decode: combinational state to control-word decode. The top level keeps the state register, next-state logic and enable/ready gating.

Test Plan:
- Reset mid-operation: assert i_reset while in EXECUTE -> o_state=0 in the same cycle, all strobes 0. Release with i_mem_ready=1 -> next cycle pc_write=1, ir_write=1.
- R-type (000000), i_mem_ready=1 -> states 0,1,6,7,0. alu_op=10 in EXECUTE. reg_write=1 and reg_dst=1 in ALU_WB. instr_done pulses once.
- lw (100011) with i_mem_ready low for 2 MEM_READ cycles -> states 0,1,2,3,3,3,4,0. mdr_write=1 only in the third MEM_READ cycle. mem_to_reg=1 in MEM_WB.
- beq (000100) -> states 0,1,8,0. BRANCH shows alu_op=01, pc_write_cond=1, pc_source=01, pc_write=0.
- Illegal opcode 111111 -> states 0,1,0. illegal_op=1 in DECODE. reg_write, mem_write and instr_done stay 0.
- i_enable=0 for 3 cycles in ALU_WB -> state held at 7 with reg_write=0. Re-enable -> reg_write=1 for exactly one cycle, then FETCH.
